// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter sharing one fabric SDRAM slave port
// between an instruction-fetch requester (m0, read-only) and a data
// load/store requester (m1). One transaction is in flight at a time; the
// downstream strobes and fields come straight from registers, and a watchdog
// aborts transactions the fabric never acknowledges.
//
// Handshake: a requester raises its strobe and holds it, with stable
// address/data, until it sees a one-cycle ack; read data is valid only
// while that ack is high. Towards the fabric, sdram_read/sdram_write stay
// high until the cycle in which sdram_acknowledge is sampled high (or the
// watchdog expires), and sdram_read_data is used only in that cycle.
module sdram_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    // m0: instruction fetch
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_read_data,
    // m1: data load/store
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byte_enable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_write_data,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_read_data,
    // fabric side
    output logic [ADDR_W-1:0] sdram_address,
    output logic [3:0]        sdram_byte_enable,
    output logic              sdram_read,
    output logic              sdram_write,
    output logic [DATA_W-1:0] sdram_write_data,
    input  logic              sdram_acknowledge,
    input  logic [DATA_W-1:0] sdram_read_data,
    // status
    output logic              busy,
    output logic              timeout_err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0]       WDOG_LAST = 16'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ABORT_WORD = DATA_W'(32'hDEAD_BEEF);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rd_stb_q, rd_stb_d;
    logic                wr_stb_q, wr_stb_d;
    logic                grant_q, grant_d;       // 0 = m0, 1 = m1
    logic                last_grant_q, last_grant_d;
    logic [15:0]         wdog_q, wdog_d;
    logic                terr_q, terr_d;

    logic                m0_pend;
    logic                m1_pend;
    logic                pick_m1;

    assign m0_pend = m0_read;
    assign m1_pend = m1_read | m1_write;
    // m1 wins when it is the only requester, or on a tie when m0 went last.
    assign pick_m1 = m1_pend & (~m0_pend | ~last_grant_q);

    // State and datapath registers; reset abandons any transaction at once.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            rd_stb_q     <= 1'b0;
            wr_stb_q     <= 1'b0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wdog_q       <= '0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rd_stb_q     <= rd_stb_d;
            wr_stb_q     <= wr_stb_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
            terr_q       <= terr_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for ack/watchdog in BUSY,
    // present the result for exactly one cycle in DONE.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rd_stb_d     = rd_stb_q;
        wr_stb_d     = wr_stb_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wdog_d       = wdog_q;
        terr_d       = terr_q;

        case (state_q)
            IDLE: begin
                if (m0_pend || m1_pend) begin
                    grant_d      = pick_m1;
                    last_grant_d = pick_m1;
                    wdog_d       = '0;
                    state_d      = BUSY;
                    if (pick_m1) begin
                        addr_d   = m1_address;
                        be_d     = m1_byte_enable;
                        wdata_d  = m1_write_data;
                        // read+write together is treated as a write
                        wr_stb_d = m1_write;
                        rd_stb_d = ~m1_write;
                    end else begin
                        addr_d   = m0_address;
                        be_d     = 4'hF;
                        wdata_d  = '0;
                        wr_stb_d = 1'b0;
                        rd_stb_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                // An ack in the same cycle the watchdog expires is a success.
                if (sdram_acknowledge) begin
                    rdata_d  = wr_stb_q ? '0 : sdram_read_data;
                    rd_stb_d = 1'b0;
                    wr_stb_d = 1'b0;
                    state_d  = DONE;
                end else if (wdog_q >= WDOG_LAST) begin
                    rdata_d  = ABORT_WORD;
                    rd_stb_d = 1'b0;
                    wr_stb_d = 1'b0;
                    terr_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                rd_stb_d = 1'b0;
                wr_stb_d = 1'b0;
            end
        endcase
    end

    assign sdram_address     = addr_q;
    assign sdram_byte_enable = be_q;
    assign sdram_write_data  = wdata_q;
    assign sdram_read        = rd_stb_q;
    assign sdram_write       = wr_stb_q;

    assign m0_ack       = (state_q == DONE) & ~grant_q;
    assign m1_ack       = (state_q == DONE) &  grant_q;
    assign m0_read_data = m0_ack ? rdata_q : '0;
    assign m1_read_data = m1_ack ? rdata_q : '0;

    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter (TIMEOUT=4). Inputs change 1 time unit
// after a rising edge; outputs are checked at that same point, so each
// check sees the state for the cycle that just began.
module tb_sdram_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic              clk_clk;
    logic              reset_reset;
    logic [ADDR_W-1:0] m0_address;
    logic              m0_read;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_read_data;
    logic [ADDR_W-1:0] m1_address;
    logic [3:0]        m1_byte_enable;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_write_data;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_read_data;
    logic [ADDR_W-1:0] sdram_address;
    logic [3:0]        sdram_byte_enable;
    logic              sdram_read;
    logic              sdram_write;
    logic [DATA_W-1:0] sdram_write_data;
    logic              sdram_acknowledge;
    logic [DATA_W-1:0] sdram_read_data;
    logic              busy;
    logic              timeout_err;
    logic [1:0]        dbg_state;

    int checks   = 0;
    int failures = 0;

    sdram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
        .clk_clk           (clk_clk),
        .reset_reset       (reset_reset),
        .m0_address        (m0_address),
        .m0_read           (m0_read),
        .m0_ack            (m0_ack),
        .m0_read_data      (m0_read_data),
        .m1_address        (m1_address),
        .m1_byte_enable    (m1_byte_enable),
        .m1_read           (m1_read),
        .m1_write          (m1_write),
        .m1_write_data     (m1_write_data),
        .m1_ack            (m1_ack),
        .m1_read_data      (m1_read_data),
        .sdram_address     (sdram_address),
        .sdram_byte_enable (sdram_byte_enable),
        .sdram_read        (sdram_read),
        .sdram_write       (sdram_write),
        .sdram_write_data  (sdram_write_data),
        .sdram_acknowledge (sdram_acknowledge),
        .sdram_read_data   (sdram_read_data),
        .busy              (busy),
        .timeout_err       (timeout_err),
        .dbg_state         (dbg_state)
    );

    // clock
    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    initial begin
        reset_reset       = 1'b1;
        m0_address        = '0;
        m0_read           = 1'b0;
        m1_address        = '0;
        m1_byte_enable    = '0;
        m1_read           = 1'b0;
        m1_write          = 1'b0;
        m1_write_data     = '0;
        sdram_acknowledge = 1'b0;
        sdram_read_data   = '0;

        // reset state
        tick();
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rd", 32'(sdram_read), 32'd0);
        check_eq("rst_wr", 32'(sdram_write), 32'd0);
        check_eq("rst_addr", 32'(sdram_address), 32'd0);
        check_eq("rst_be", 32'(sdram_byte_enable), 32'd0);
        check_eq("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        check_eq("rst_m0d", m0_read_data, 32'd0);
        check_eq("rst_terr", 32'(timeout_err), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk_clk);
        reset_reset = 1'b0;
        tick();

        // --- single m0 fetch, fabric acks in cycle 2 ---
        m0_address = 16'h0040;
        m0_read    = 1'b1;                      // cycle 0
        check_eq("t1_c0_busy", 32'(busy), 32'd0);
        tick();                                 // cycle 1
        check_eq("t1_c1_rd", 32'(sdram_read), 32'd1);
        check_eq("t1_c1_addr", 32'(sdram_address), 32'h0040);
        check_eq("t1_c1_be", 32'(sdram_byte_enable), 32'hF);
        check_eq("t1_c1_wr", 32'(sdram_write), 32'd0);
        check_eq("t1_c1_busy", 32'(busy), 32'd1);
        tick();                                 // cycle 2
        check_eq("t1_c2_rd", 32'(sdram_read), 32'd1);
        check_eq("t1_c2_ack", 32'(m0_ack), 32'd0);
        sdram_acknowledge = 1'b1;
        sdram_read_data   = 32'h1234_5678;
        tick();                                 // cycle 3
        sdram_acknowledge = 1'b0;
        sdram_read_data   = 32'h0;
        check_eq("t1_c3_m0ack", 32'(m0_ack), 32'd1);
        check_eq("t1_c3_m0d", m0_read_data, 32'h1234_5678);
        check_eq("t1_c3_m1ack", 32'(m1_ack), 32'd0);
        check_eq("t1_c3_rd", 32'(sdram_read), 32'd0);
        check_eq("t1_c3_busy", 32'(busy), 32'd1);
        m0_read = 1'b0;
        tick();                                 // cycle 4
        check_eq("t1_c4_m0ack", 32'(m0_ack), 32'd0);
        check_eq("t1_c4_m0d", m0_read_data, 32'd0);
        check_eq("t1_c4_busy", 32'(busy), 32'd0);

        // --- m1 write, ack in first strobe cycle ---
        m1_address     = 16'h00A0;
        m1_byte_enable = 4'b0011;
        m1_write_data  = 32'hCAFE_F00D;
        m1_write       = 1'b1;                  // cycle 0
        tick();                                 // cycle 1
        check_eq("t2_wr", 32'(sdram_write), 32'd1);
        check_eq("t2_rd", 32'(sdram_read), 32'd0);
        check_eq("t2_addr", 32'(sdram_address), 32'h00A0);
        check_eq("t2_be", 32'(sdram_byte_enable), 32'h3);
        check_eq("t2_wdata", sdram_write_data, 32'hCAFE_F00D);
        sdram_acknowledge = 1'b1;
        sdram_read_data   = 32'h5555_AAAA;      // must not be captured on a write
        tick();                                 // cycle 2
        sdram_acknowledge = 1'b0;
        check_eq("t2_m1ack", 32'(m1_ack), 32'd1);
        check_eq("t2_m1d", m1_read_data, 32'd0);
        check_eq("t2_m0ack", 32'(m0_ack), 32'd0);
        check_eq("t2_wr_off", 32'(sdram_write), 32'd0);
        m1_write = 1'b0;
        tick();
        check_eq("t2_idle", 32'(busy), 32'd0);

        // --- contention: both held, fabric acks immediately ---
        m0_address = 16'h0100;
        m1_address = 16'h0200;
        m1_byte_enable = 4'b1111;
        m0_read = 1'b1;
        m1_read = 1'b1;
        sdram_acknowledge = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic exp_m1;
            exp_m1 = (i % 2) == 1;
            sdram_read_data = 32'h1000_0000 + 32'(i);
            tick();                             // BUSY
            check_eq($sformatf("t3_%0d_rd", i), 32'(sdram_read), 32'd1);
            check_eq($sformatf("t3_%0d_addr", i), 32'(sdram_address),
                     exp_m1 ? 32'h0200 : 32'h0100);
            tick();                             // DONE
            check_eq($sformatf("t3_%0d_acks", i), {30'd0, m1_ack, m0_ack},
                     exp_m1 ? 32'd2 : 32'd1);
            check_eq($sformatf("t3_%0d_data", i), exp_m1 ? m1_read_data : m0_read_data,
                     32'h1000_0000 + 32'(i));
            if (i == 5) begin
                m0_read = 1'b0;
                m1_read = 1'b0;
                sdram_acknowledge = 1'b0;
            end
            tick();                             // IDLE
            check_eq($sformatf("t3_%0d_idle", i), {29'd0, busy, m1_ack, m0_ack}, 32'd0);
        end
        tick();
        check_eq("t3_quiet", 32'(busy), 32'd0);

        // --- m1 read, fabric never acks: watchdog after 4 BUSY cycles ---
        m1_address = 16'h0300;
        m1_read    = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            tick();
            check_eq($sformatf("t4_busy%0d_rd", n), 32'(sdram_read), 32'd1);
            check_eq($sformatf("t4_busy%0d_terr", n), 32'(timeout_err), 32'd0);
        end
        tick();                                 // DONE
        check_eq("t4_rd_off", 32'(sdram_read), 32'd0);
        check_eq("t4_m1ack", 32'(m1_ack), 32'd1);
        check_eq("t4_m1d", m1_read_data, 32'hDEAD_BEEF);
        check_eq("t4_terr", 32'(timeout_err), 32'd1);
        m1_read = 1'b0;
        tick();
        // follow-up good transaction keeps the sticky flag
        m0_address = 16'h0044;
        m0_read    = 1'b1;
        tick();                                 // BUSY
        sdram_acknowledge = 1'b1;
        sdram_read_data   = 32'h0BAD_F00D;
        tick();                                 // DONE
        sdram_acknowledge = 1'b0;
        check_eq("t4_good_ack", 32'(m0_ack), 32'd1);
        check_eq("t4_good_d", m0_read_data, 32'h0BAD_F00D);
        check_eq("t4_terr_sticky", 32'(timeout_err), 32'd1);
        m0_read = 1'b0;
        tick();

        // --- asynchronous reset mid-BUSY ---
        m0_address = 16'h0500;
        m0_read    = 1'b1;
        tick();                                 // BUSY
        check_eq("t5_rd_before", 32'(sdram_read), 32'd1);
        #2;
        reset_reset = 1'b1;
        #1;                                     // still before the next edge
        check_eq("t5_rd_async", 32'(sdram_read), 32'd0);
        check_eq("t5_busy_async", 32'(busy), 32'd0);
        check_eq("t5_terr_clr", 32'(timeout_err), 32'd0);
        m1_address = 16'h0600;
        m1_read    = 1'b1;                      // tie after reset
        @(negedge clk_clk);
        reset_reset = 1'b0;
        tick();                                 // BUSY: m0 must win
        check_eq("t5_tie_rd", 32'(sdram_read), 32'd1);
        check_eq("t5_tie_addr", 32'(sdram_address), 32'h0500);
        sdram_acknowledge = 1'b1;
        sdram_read_data   = 32'h7777_0001;
        tick();                                 // DONE
        sdram_acknowledge = 1'b0;
        check_eq("t5_tie_acks", {30'd0, m1_ack, m0_ack}, 32'd1);
        m0_read = 1'b0;
        m1_read = 1'b0;
        tick();

        // --- m1 read and write together: treated as a write ---
        m1_address     = 16'h0700;
        m1_byte_enable = 4'b1000;
        m1_write_data  = 32'h0102_0304;
        m1_read        = 1'b1;
        m1_write       = 1'b1;
        tick();                                 // BUSY
        check_eq("t6_wr", 32'(sdram_write), 32'd1);
        check_eq("t6_rd", 32'(sdram_read), 32'd0);
        check_eq("t6_be", 32'(sdram_byte_enable), 32'h8);
        sdram_acknowledge = 1'b1;
        sdram_read_data   = 32'hFFFF_FFFF;
        tick();                                 // DONE
        sdram_acknowledge = 1'b0;
        check_eq("t6_m1ack", 32'(m1_ack), 32'd1);
        check_eq("t6_m1d", m1_read_data, 32'd0);
        check_eq("t6_rd_done", 32'(sdram_read), 32'd0);
        m1_read  = 1'b0;
        m1_write = 1'b0;
        tick();
        check_eq("t6_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
